// File: rtl/ucnt_pkg.sv
// ucnt_pkg: shared widths and FSM encoding for the 8-bit counter/timer family.
// Used by ucapture8, its interface and its sub-modules.
package ucnt_pkg;

  localparam int CW_DEF   = 8;
  localparam int PW_DEF   = 16;
  localparam int SYNC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIRST = 2'b01,
    RUN   = 2'b10
  } state_t;

endpackage

// File: rtl/ucapture8_if.sv
// ucapture8_if: timer-side inputs, event input and host result handshake.
// master = timer/host/event side, slave = capture unit.
interface ucapture8_if
  import ucnt_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
) ();

  logic [CW-1:0] dcount;
  logic          cnt_wrap;
  logic          evt_in;
  logic          _edge_sel;
  logic          arm;
  logic          rd_ack;
  logic [CW-1:0] cap_val;
  logic [PW-1:0] period;
  logic          cap_valid;
  logic          missed;
  logic          per_ovf;

  modport master (
    output dcount, cnt_wrap, evt_in,
    output _edge_sel, arm, rd_ack,
    input  cap_val, period, cap_valid,
    input  missed, per_ovf
  );

  modport slave (
    input  dcount, cnt_wrap, evt_in,
    input  _edge_sel, arm, rd_ack,
    output cap_val, period, cap_valid,
    output missed, per_ovf
  );

endinterface

// File: rtl/edge_sync.sv
// edge_sync: SYNC_N-flop synchroniser plus polarity-selectable edge pulse.
// Ports: clk, _areset (sync, low), i_evt (async), i_rise (1=rising), o_pulse.
module edge_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic _areset,
  input  logic i_evt,
  input  logic i_rise,
  output logic o_pulse
);

  logic [SYNC_N-1:0] r_sync;
  logic              r_dly;
  logic              w_lvl;

  always_ff @(posedge clk) begin
    if (!_areset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], i_evt};
      r_dly  <= r_sync[SYNC_N-1];
    end
  end

  assign w_lvl = r_sync[SYNC_N-1];

  // Combinational pulse so the FSM registers the result one clock later.
  assign o_pulse = i_rise ? (w_lvl & ~r_dly)
                          : (~w_lvl & r_dly);

endmodule

// File: rtl/ucapture8.sv
// ucapture8: input-capture / period-measurement reader for the 8-bit timer.
// Ports: clk, _areset (sync, low), bus (ucapture8_if.slave).
module ucapture8
  import ucnt_pkg::*;
#(
  parameter int CW     = CW_DEF,
  parameter int PW     = PW_DEF,
  parameter int SYNC_N = SYNC_DEF
) (
  input logic  clk,
  input logic  _areset,
  ucapture8_if.slave bus
);

  localparam int WW = PW - CW;

  state_t        r_state;
  logic [WW-1:0] r_wrap;
  logic [CW-1:0] r_prev;
  logic [CW-1:0] r_cap;
  logic [PW-1:0] r_per;
  logic          r_valid;
  logic          r_missed;
  logic          r_ovf;

  logic          w_edge;
  logic          w_full;
  logic [WW-1:0] w_wrap_inc;
  logic [WW-1:0] w_wrap_eff;
  logic [PW-1:0] w_period;
  logic          w_load;

  edge_sync #(
    .SYNC_N (SYNC_N)
  ) u_sync (
    .clk     (clk),
    ._areset (_areset),
    .i_evt   (bus.evt_in),
    .i_rise  (bus._edge_sel),
    .o_pulse (w_edge)
  );

  assign w_full     = &r_wrap;
  assign w_wrap_inc = r_wrap + WW'(1);

  // A wrap landing with the edge belongs to the period being closed.
  assign w_wrap_eff = (bus.cnt_wrap && !w_full)
                    ? w_wrap_inc : r_wrap;

  assign w_period = {w_wrap_eff, {CW{1'b0}}}
                  + PW'(bus.dcount)
                  - PW'(r_prev);

  // rd_ack frees the slot in the same cycle a new edge arrives.
  assign w_load = !r_valid || bus.rd_ack;

  always_ff @(posedge clk) begin
    if (!_areset) begin
      r_state  <= IDLE;
      r_wrap   <= '0;
      r_prev   <= '0;
      r_cap    <= '0;
      r_per    <= '0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (bus.rd_ack && r_valid)
        r_valid <= 1'b0;
      if (!bus.arm) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state  <= FIRST;
            r_missed <= 1'b0;
            r_ovf    <= 1'b0;
            r_wrap   <= '0;
          end
          FIRST: begin
            if (w_edge) begin
              r_prev  <= bus.dcount;
              r_wrap  <= '0;
              r_state <= RUN;
            end else if (bus.cnt_wrap) begin
              if (w_full) r_ovf  <= 1'b1;
              else        r_wrap <= w_wrap_inc;
            end
          end
          RUN: begin
            if (w_edge) begin
              r_prev <= bus.dcount;
              r_wrap <= '0;
              if (bus.cnt_wrap && w_full)
                r_ovf <= 1'b1;
              if (w_load) begin
                r_cap   <= bus.dcount;
                r_per   <= w_period;
                r_valid <= 1'b1;
              end else begin
                r_missed <= 1'b1;
              end
            end else if (bus.cnt_wrap) begin
              if (w_full) r_ovf  <= 1'b1;
              else        r_wrap <= w_wrap_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cap_val   = r_cap;
  assign bus.period    = r_per;
  assign bus.cap_valid = r_valid;
  assign bus.missed    = r_missed;
  assign bus.per_ovf   = r_ovf;

endmodule

// File: tb/tb_ucapture8.sv
// tb_ucapture8: directed-vector bench for ucapture8.
// Drives the interface master side; checks results against hand values.
module tb_ucapture8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ucapture8_if #(.CW(8), .PW(16)) bus ();

  ucapture8 #(.CW(8), .PW(16), .SYNC_N(2)) dut (
    .clk     (clk),
    ._areset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_edge(input logic lvl, input logic [7:0] dc,
                         input logic wr, input logic ak);
    bus.dcount = dc;
    bus.evt_in = lvl;
    tick();
    tick();
    bus.cnt_wrap = wr;
    bus.rd_ack   = ak;
    tick();
    bus.cnt_wrap = 1'b0;
    bus.rd_ack   = 1'b0;
  endtask

  task automatic ack();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.arm = 1'b1;
    bus.evt_in = 1'b1;
    tick();
    bus.evt_in = 1'b0;
    tick();
    bus.evt_in = 1'b1;
    tick();
    n_cmp++;
    if (bus.cap_val !== 8'd0 || bus.period !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_results got %0d/%0d want 0/0",
               bus.cap_val, bus.period);
    end
    n_cmp++;
    if ({bus.cap_valid, bus.missed, bus.per_ovf} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000",
               {bus.cap_valid, bus.missed, bus.per_ovf});
    end
    n_cmp++;
    if (dut.r_state !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state got %0d want 0", dut.r_state);
    end
    bus.arm = 1'b0;
    bus.evt_in = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    bus._edge_sel = 1'b1;
    bus.arm = 1'b1;
    tick();
    n_cmp++;
    if (dut.r_state !== 2'b01) begin
      n_bad++;
      $display("FAIL arm_first got %0d want 1", dut.r_state);
    end
    do_edge(1'b1, 8'd10, 1'b0, 1'b0);
    n_cmp++;
    if (dut.r_state !== 2'b10 || bus.cap_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_edge state/valid got %0d/%b want 2/0",
               dut.r_state, bus.cap_valid);
    end
    do_edge(1'b0, 8'd10, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrong_polarity valid got %b want 0", bus.cap_valid);
    end
    bus.dcount = 8'd50;
    bus.evt_in = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.cap_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early valid got %b want 0", bus.cap_valid);
    end
    tick();
    n_cmp++;
    if (bus.cap_valid !== 1'b1 || bus.cap_val !== 8'd50) begin
      n_bad++;
      $display("FAIL basic_cap valid/val got %b/%0d want 1/50",
               bus.cap_valid, bus.cap_val);
    end
    n_cmp++;
    if (bus.period !== 16'd40) begin
      n_bad++;
      $display("FAIL basic_period got %0d want 40", bus.period);
    end
    ack();
    n_cmp++;
    if (bus.cap_valid !== 1'b0 || bus.cap_val !== 8'd50) begin
      n_bad++;
      $display("FAIL basic_ack valid/val got %b/%0d want 0/50",
               bus.cap_valid, bus.cap_val);
    end
  endtask

  task automatic test_wrap();
    do_edge(1'b0, 8'd50, 1'b0, 1'b0);
    do_edge(1'b1, 8'd200, 1'b0, 1'b0);
    n_cmp++;
    if (bus.period !== 16'd150) begin
      n_bad++;
      $display("FAIL nowrap_period got %0d want 150", bus.period);
    end
    ack();
    do_edge(1'b0, 8'd200, 1'b0, 1'b0);
    bus.cnt_wrap = 1'b1;
    tick();
    bus.cnt_wrap = 1'b0;
    do_edge(1'b1, 8'd20, 1'b0, 1'b0);
    n_cmp++;
    if (bus.period !== 16'd76 || bus.cap_val !== 8'd20) begin
      n_bad++;
      $display("FAIL wrap_period per/val got %0d/%0d want 76/20",
               bus.period, bus.cap_val);
    end
    ack();
    do_edge(1'b0, 8'd20, 1'b0, 1'b0);
    do_edge(1'b1, 8'd250, 1'b0, 1'b0);
    n_cmp++;
    if (bus.period !== 16'd230) begin
      n_bad++;
      $display("FAIL pre_same_period got %0d want 230", bus.period);
    end
    ack();
    do_edge(1'b0, 8'd250, 1'b0, 1'b0);
    do_edge(1'b1, 8'd0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.period !== 16'd6 || bus.cap_val !== 8'd0) begin
      n_bad++;
      $display("FAIL same_cycle_wrap per/val got %0d/%0d want 6/0",
               bus.period, bus.cap_val);
    end
    ack();
  endtask

  task automatic test_overrun();
    do_edge(1'b0, 8'd0, 1'b0, 1'b0);
    do_edge(1'b1, 8'd30, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_val !== 8'd30 || bus.period !== 16'd30) begin
      n_bad++;
      $display("FAIL ovr_first val/per got %0d/%0d want 30/30",
               bus.cap_val, bus.period);
    end
    do_edge(1'b0, 8'd30, 1'b0, 1'b0);
    do_edge(1'b1, 8'd70, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_val !== 8'd30 || bus.period !== 16'd30) begin
      n_bad++;
      $display("FAIL ovr_held val/per got %0d/%0d want 30/30",
               bus.cap_val, bus.period);
    end
    n_cmp++;
    if (bus.missed !== 1'b1 || bus.cap_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_missed missed/valid got %b/%b want 1/1",
               bus.missed, bus.cap_valid);
    end
    do_edge(1'b0, 8'd70, 1'b0, 1'b0);
    do_edge(1'b1, 8'd100, 1'b0, 1'b1);
    n_cmp++;
    if (bus.cap_val !== 8'd100 || bus.period !== 16'd30) begin
      n_bad++;
      $display("FAIL ack_edge val/per got %0d/%0d want 100/30",
               bus.cap_val, bus.period);
    end
    n_cmp++;
    if (bus.cap_valid !== 1'b1 || bus.missed !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_edge valid/missed got %b/%b want 1/1",
               bus.cap_valid, bus.missed);
    end
    ack();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      bus.cnt_wrap = 1'b1;
      tick();
      bus.cnt_wrap = 1'b0;
      tick();
    end
    n_cmp++;
    if (bus.per_ovf !== 1'b1 || bus.missed !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_ovf ovf/missed got %b/%b want 1/1",
               bus.per_ovf, bus.missed);
    end
    bus.arm = 1'b0;
    tick();
    n_cmp++;
    if (dut.r_state !== 2'b00 || bus.per_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL disarm state/ovf got %0d/%b want 0/1",
               dut.r_state, bus.per_ovf);
    end
    bus.arm = 1'b1;
    tick();
    n_cmp++;
    if (bus.per_ovf !== 1'b0 || bus.missed !== 1'b0) begin
      n_bad++;
      $display("FAIL rearm_clear ovf/missed got %b/%b want 0/0",
               bus.per_ovf, bus.missed);
    end
  endtask

  task automatic test_falling_abort();
    bus._edge_sel = 1'b0;
    tick();
    do_edge(1'b0, 8'd40, 1'b0, 1'b0);
    n_cmp++;
    if (dut.r_state !== 2'b10 || bus.cap_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fall_first state/valid got %0d/%b want 2/0",
               dut.r_state, bus.cap_valid);
    end
    do_edge(1'b1, 8'd60, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fall_rise_ignored valid got %b want 0",
               bus.cap_valid);
    end
    do_edge(1'b0, 8'd90, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_val !== 8'd90 || bus.period !== 16'd50 ||
        bus.cap_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fall_cap val/per/valid got %0d/%0d/%b want 90/50/1",
               bus.cap_val, bus.period, bus.cap_valid);
    end
    ack();
    do_edge(1'b1, 8'd100, 1'b0, 1'b0);
    bus.arm = 1'b0;
    tick();
    n_cmp++;
    if (dut.r_state !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_state got %0d want 0", dut.r_state);
    end
    do_edge(1'b0, 8'd120, 1'b0, 1'b0);
    n_cmp++;
    if (bus.cap_valid !== 1'b0 || bus.cap_val !== 8'd90) begin
      n_bad++;
      $display("FAIL abort_edge valid/val got %b/%0d want 0/90",
               bus.cap_valid, bus.cap_val);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.dcount    = 8'd0;
    bus.cnt_wrap  = 1'b0;
    bus.evt_in    = 1'b0;
    bus._edge_sel = 1'b1;
    bus.arm       = 1'b0;
    bus.rd_ack    = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_saturation();
    test_falling_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
